// File: rtl/obstacle_scroller.sv
// Scrolls one obstacle column right-to-left, handshakes with the gap position
// sequencer at the left edge, and renders a registered per-pixel obstacle flag.
// Optional: define OBS_SPEEDUP_EN to raise the step by 1 every 8 passes (max 8).
module obstacle_scroller #(
  parameter int H_RES = 640,
  parameter int OBS_W = 40,
  parameter int GAP_H = 120,
  parameter int STEP  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [9:0] i_posy,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic       change,
  output logic [9:0] obs_x,
  output logic [9:0] gap_top,
  output logic       o_obstacle,
  output logic [7:0] o_score
);

  typedef enum logic [2:0] {IDLE, WAIT, LOAD, MOVE, REQ} state_t;

  localparam logic [9:0]  H_RES_V = 10'(H_RES);
  localparam logic [10:0] OBS_W_V = 11'(OBS_W);
  localparam logic [10:0] GAP_H_V = 11'(GAP_H);

  state_t     state, state_nxt;
  logic       settle_cnt;
  logic [9:0] step;
  logic       tick_en;
  logic       at_edge;
  logic       pass_done;

`ifdef OBS_SPEEDUP_EN
  logic [3:0] step_q;
  assign step = {6'd0, step_q};
`else
  assign step = 10'(STEP);
`endif

  assign tick_en   = frame_tick & enable;
  assign at_edge   = (obs_x < step);
  assign pass_done = (state == MOVE) && tick_en && at_edge;

  always_comb begin
    state_nxt = state;
    change    = 1'b0;
    case (state)
      IDLE: if (enable) state_nxt = WAIT;
      WAIT: if (settle_cnt) state_nxt = LOAD;
      LOAD: state_nxt = MOVE;
      MOVE: if (tick_en && at_edge) state_nxt = REQ;
      REQ: begin
        change    = 1'b1;
        state_nxt = WAIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= 1'b0;
      obs_x      <= H_RES_V;
      gap_top    <= 10'd0;
      o_score    <= 8'd0;
`ifdef OBS_SPEEDUP_EN
      step_q     <= 4'(STEP);
`endif
    end else begin
      state <= state_nxt;
      // Two-cycle settle: counter toggles 0 -> 1 while waiting, leaves on 1
      settle_cnt <= (state == WAIT) ? ~settle_cnt : 1'b0;
      if (state == LOAD) begin
        gap_top <= i_posy;
        obs_x   <= H_RES_V;
      end else if ((state == MOVE) && tick_en && !at_edge) begin
        obs_x <= obs_x - step;
      end
      if (pass_done && (o_score != 8'hFF)) begin
        o_score <= o_score + 8'd1;
`ifdef OBS_SPEEDUP_EN
        if ((o_score[2:0] == 3'd7) && (step_q < 4'd8)) step_q <= step_q + 4'd1;
`endif
      end
    end
  end

  // Render stage: sums widened to 11 bits so column/gap ends never wrap
  logic [10:0] x_end, gap_end;
  logic        obstacle_p0;

  assign x_end   = {1'b0, obs_x} + OBS_W_V;
  assign gap_end = {1'b0, gap_top} + GAP_H_V;
  assign obstacle_p0 = (state != IDLE)
                    && (pixel_x >= obs_x)
                    && ({1'b0, pixel_x} < x_end)
                    && ((pixel_y < gap_top) || ({1'b0, pixel_y} >= gap_end));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_obstacle <= 1'b0;
    else     o_obstacle <= obstacle_p0;
  end

endmodule

// File: tb/tb_obstacle_scroller.sv
// Scoreboard bench for obstacle_scroller: a frame-level reference model predicts
// column position, gap, score, change pulses and per-pixel obstacle flags.
module tb_obstacle_scroller;

  localparam int H_RES = 640;
  localparam int OBS_W = 40;
  localparam int GAP_H = 120;
  localparam int STEP  = 2;
  localparam int NPOS  = 512;
`ifdef OBS_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] i_posy = 10'd0;
  logic [9:0] pixel_x = 10'd0;
  logic [9:0] pixel_y = 10'd0;
  logic       change;
  logic [9:0] obs_x, gap_top;
  logic       o_obstacle;
  logic [7:0] o_score;

  obstacle_scroller #(.H_RES(H_RES), .OBS_W(OBS_W), .GAP_H(GAP_H), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick),
    .i_posy(i_posy), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .change(change), .obs_x(obs_x), .gap_top(gap_top),
    .o_obstacle(o_obstacle), .o_score(o_score)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Upstream position sequencer: advances to the next table entry on change
  logic [9:0] pos_list [NPOS];
  int seq_idx = 0;
  initial begin
    pos_list[0] = 10'd350;
    pos_list[1] = 10'd280;
    pos_list[2] = 10'd950;
    for (int i = 3; i < NPOS; i++) pos_list[i] = 10'($urandom_range(0, 1023));
    i_posy = pos_list[0];
    forever begin
      @(posedge clk); #1;
      if (change) begin
        seq_idx = (seq_idx + 1) % NPOS;
        i_posy  = pos_list[seq_idx];
      end
    end
  end

  // Reference model, advanced once per clock from the sampled inputs
  bit m_run = 0;
  int m_busy = 0;
  int m_x = H_RES;
  int m_gap = 0;
  int m_score = 0;
  int m_step = STEP;
  int m_idx = 0;
  int m_passes = 0;
  int scoreq[$];
  bit pixq[$];
  bit pix_vld = 0;
  bit pix_vld_q = 0;

  function automatic bit exp_obs(input int x, input int y);
    return m_run && (x >= m_x) && (x < m_x + OBS_W) && ((y < m_gap) || (y >= m_gap + GAP_H));
  endfunction

  initial forever begin
    @(posedge clk);
    pix_vld_q = pix_vld;
    if (pix_vld) pixq.push_back(rst ? 1'b0 : exp_obs(int'(pixel_x), int'(pixel_y)));
    if (rst) begin
      m_run = 0; m_busy = 0; m_x = H_RES; m_gap = 0; m_score = 0; m_step = STEP;
    end else if (!m_run) begin
      if (enable) begin m_run = 1; m_busy = 3; end
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin m_x = H_RES; m_gap = int'(pos_list[m_idx]); end
    end else if (enable && frame_tick) begin
      if (m_x >= m_step) m_x -= m_step;
      else begin
        m_passes++;
        if (m_score < 255) begin
          m_score++;
          if (SPEEDUP && (m_score % 8 == 0) && (m_step < 8)) m_step++;
        end
        scoreq.push_back(m_score);
        m_idx  = (m_idx + 1) % NPOS;
        m_busy = 4;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a flag or a change pulse
  int  chg_count = 0;
  bit  prev_change = 0;
  initial forever begin
    @(negedge clk);
    if (pix_vld_q) begin
      if (pixq.size() == 0) check("pixq_underflow", 1, 0);
      else check("o_obstacle", int'(o_obstacle), int'(pixq.pop_front()));
    end
    if (!rst) begin
      check("obs_x_track", int'(obs_x), m_x);
      check("gap_top_track", int'(gap_top), m_gap);
      check("o_score_track", int'(o_score), m_score);
    end
    if (prev_change) check("change_width", int'(change), 0);
    if (change) begin
      chg_count++;
      if (scoreq.size() == 0) check("unexpected_change", 1, 0);
      else check("score_at_change", int'(o_score), scoreq.pop_front());
    end
    prev_change = change;
  end

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 frame_tick = 1'b1;
    end
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  task automatic pix(input int x, input int y);
    @(posedge clk); #1;
    pixel_x = 10'(x); pixel_y = 10'(y); pix_vld = 1'b1;
    @(posedge clk); #1 pix_vld = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_passes(input int n);
    int target;
    int cyc;
    target = m_passes + n;
    cyc = 0;
    @(posedge clk); #1 frame_tick = 1'b1;
    while ((m_passes < target) && (cyc < 40000)) begin
      @(posedge clk); #1;
      cyc++;
    end
    frame_tick = 1'b0;
    check("passes_done", m_passes, target);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_change", int'(change), 0);
    check("rst_obs_x", int'(obs_x), H_RES);
    check("rst_gap_top", int'(gap_top), 0);
    check("rst_obstacle", int'(o_obstacle), 0);
    check("rst_score", int'(o_score), 0);

    @(posedge clk); #2 rst = 1'b0; enable = 1'b1;
    settle(4);
    check("first_gap", int'(gap_top), 350);
    check("first_obs_x", int'(obs_x), 640);
    check("no_change_yet", chg_count, 0);

    ticks(320);
    @(negedge clk);
    check("left_edge", int'(obs_x), 0);
    ticks(1);
    @(negedge clk);
    check("change_pulse", int'(change), 1);
    check("score_one", int'(o_score), 1);
    settle(5);
    check("second_gap", int'(gap_top), 280);
    check("reload_x", int'(obs_x), 640);

    pix(640, 279);
    pix(640, 340);
    pix(640, 400);
    pix(680, 279);
    pix(639, 279);

    ticks(120);
    @(negedge clk);
    check("at_400", int'(obs_x), 400);
    enable = 1'b0;
    ticks(10);
    @(negedge clk);
    check("frozen", int'(obs_x), 400);
    enable = 1'b1;
    ticks(1);
    @(negedge clk);
    check("resume", int'(obs_x), 398);

    ticks(199);
    ticks(2);
    settle(5);
    check("req_tick_dropped", int'(obs_x), 640);
    check("third_gap", int'(gap_top), 950);
    check("score_two", int'(o_score), 2);
    pix(650, 1000);
    pix(650, 949);
    pix(650, 1023);

    ticks(320);
    ticks(1);
    #1 rst = 1'b1;
    scoreq.delete();
    #1;
    check("rst_req_change", int'(change), 0);
    check("rst_req_score", int'(o_score), 0);
    check("rst_req_obs_x", int'(obs_x), 640);
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    pix(640, 200);

`ifdef OBS_SPEEDUP_EN
    enable = 1'b1;
    settle(5);
    run_passes(8);
    settle(6);
    check("sp_reload", int'(obs_x), 640);
    ticks(1);
    @(negedge clk);
    check("sp_step3", int'(obs_x), 637);
    run_passes(292);
    settle(6);
    check("sp_score_sat", int'(o_score), 255);
    ticks(1);
    @(negedge clk);
    check("sp_step8", int'(obs_x), 632);
`endif

    for (int c = 0; c < 4000; c++) begin
      int px;
      @(posedge clk); #1;
      enable     = ($urandom_range(0, 9) != 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      px = ($urandom_range(0, 1) == 0) ? (m_x + int'($urandom_range(0, 46)) - 3)
                                        : int'($urandom_range(0, 1023));
      if (px < 0) px = 0;
      if (px > 1023) px = 1023;
      pixel_x = 10'(px);
      pixel_y = 10'($urandom_range(0, 1023));
      pix_vld = 1'b1;
    end
    @(posedge clk); #1;
    pix_vld = 1'b0; frame_tick = 1'b0; enable = 1'b0;
    settle(3);
    check("scoreq_drained", scoreq.size(), 0);
    check("pixq_drained", pixq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
